// File: rtl/tdm_demux_if.sv
// Port bundle for tdm_demux: serial slot input plus the two per-channel
// valid/ready word outputs. "slave" is the demux side, "master" the upstream/consumer side.
interface tdm_demux_if #(
   parameter int WIDTH = 8
);
   logic             data;
   logic             sel;
   logic             in_valid;
   logic             sof;

   logic [WIDTH-1:0] out_a;
   logic             out_a_valid;
   logic             out_a_ready;
   logic [WIDTH-1:0] out_b;
   logic             out_b_valid;
   logic             out_b_ready;

   logic             overflow_a;
   logic             overflow_b;
   logic             parity_err_a;
   logic             parity_err_b;

   modport slave (
      input  data, sel, in_valid, sof, out_a_ready, out_b_ready,
      output out_a, out_a_valid, out_b, out_b_valid,
      output overflow_a, overflow_b, parity_err_a, parity_err_b
   );

   modport master (
      output data, sel, in_valid, sof, out_a_ready, out_b_ready,
      input  out_a, out_a_valid, out_b, out_b_valid,
      input  overflow_a, overflow_b, parity_err_a, parity_err_b
   );
endinterface

// File: rtl/tdm_demux.sv
// Two-channel TDM serial receiver: per-channel LSB-first deserializer with a
// one-word output buffer. Define TDM_DEMUX_PARITY_EN for a trailing even-parity bit per word.
module tdm_demux #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   tdm_demux_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0] shift;
      logic [CW-1:0]    cnt;
      logic [WIDTH-1:0] word;
      logic             valid;
      logic             ovf;
   } lane_t;

   logic [1:0] ready;
   assign ready = {bus.out_b_ready, bus.out_a_ready};

   for (genvar g = 0; g < 2; g++) begin : g_lane
      lane_t            lane_q, lane_d;
      logic             accept, take, complete, par_ok, load;
      logic [CW-1:0]    idx;
      logic [WIDTH-1:0] assembled;
`ifdef TDM_DEMUX_PARITY_EN
      logic             perr_q, perr_d;
`endif

      always_comb begin
         // NOTE: every comb output gets a default first so no path can infer a latch.
         lane_d    = lane_q;
         accept    = bus.in_valid && (bus.sel == 1'(g));
         take      = lane_q.valid && ready[g];
         // sof restarts the word: the incoming bit lands at position 0.
         idx       = bus.sof ? '0 : lane_q.cnt;
         assembled = lane_q.shift;
         for (int k = 0; k < WIDTH; k++) begin
            if (idx == CW'(k)) assembled[k] = bus.data;
         end
         complete  = accept && (idx == CW'(N - 1));
`ifdef TDM_DEMUX_PARITY_EN
         par_ok    = ((^lane_q.shift) == bus.data);
         perr_d    = complete && !par_ok;
`else
         par_ok    = 1'b1;
`endif
         load      = complete && par_ok && (!lane_q.valid || take);

         if (accept) begin
            lane_d.shift = assembled;
            lane_d.cnt   = complete ? '0 : idx + 1'b1;
         end
         if (load) begin
            lane_d.word  = assembled;
            lane_d.valid = 1'b1;
         end else if (take) begin
            lane_d.valid = 1'b0;
         end
         if (complete && par_ok && !load) lane_d.ovf = 1'b1;
      end

      // NOTE: state registers use non-blocking assignments so all flops update together.
      always_ff @(posedge clk) begin
         if (reset) begin
            lane_q <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            perr_q <= 1'b0;
`endif
         end else begin
            lane_q <= lane_d;
`ifdef TDM_DEMUX_PARITY_EN
            perr_q <= perr_d;
`endif
         end
      end
   end

   assign bus.out_a       = g_lane[0].lane_q.word;
   assign bus.out_a_valid = g_lane[0].lane_q.valid;
   assign bus.overflow_a  = g_lane[0].lane_q.ovf;
   assign bus.out_b       = g_lane[1].lane_q.word;
   assign bus.out_b_valid = g_lane[1].lane_q.valid;
   assign bus.overflow_b  = g_lane[1].lane_q.ovf;

`ifdef TDM_DEMUX_PARITY_EN
   assign bus.parity_err_a = g_lane[0].perr_q;
   assign bus.parity_err_b = g_lane[1].perr_q;
`else
   assign bus.parity_err_a = 1'b0;
   assign bus.parity_err_b = 1'b0;
`endif

endmodule
